// File: rtl/i2c_pkg.sv
// Shared I2C definitions: responder FSM states and R/W bit encoding.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        REG,
        REG_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        MACK
    } i2c_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and derives bus events.
// Flops reset to 1 (idle bus) so no event fires right after reset.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det,
    output logic o_sda_s
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl_s;
    logic                   w_sda_s;

    assign w_scl_s = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s = r_sda_sync[SYNC_STAGES-1];

    // Synchronizer chains plus one previous-sample flop per line
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl_s;
            r_sda_prev <= w_sda_s;
        end
    end

    // START/STOP require SCL high on both samples so they never alias an SCL edge
    assign o_scl_rise  =  w_scl_s & ~r_scl_prev;
    assign o_scl_fall  = ~w_scl_s &  r_scl_prev;
    assign o_start_det =  w_scl_s &  r_scl_prev &  r_sda_prev & ~w_sda_s;
    assign o_stop_det  =  w_scl_s &  r_scl_prev & ~r_sda_prev &  w_sda_s;
    assign o_sda_s     =  w_sda_s;

endmodule

// File: rtl/i2c_slave_regif.sv
// I2C responder bridging bus transfers to an 8-bit register port.
// Write: addr byte, register pointer, data bytes (auto-increment).
// Read: data fetched ahead of the SCL fall that must present bit 7.
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h68,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_sda_oe,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    output logic       o_reg_we,
    output logic       o_reg_re,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy
);

    i2c_state_t r_state, w_state_nxt;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift, r_reg_addr, r_reg_wdata;
    logic       r_sda_oe, r_reg_we, r_reg_re, r_re_d, r_busy, r_rw, r_first;

    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;
    logic w_rx_state, w_shift_rx, w_ack_drive, w_we, w_re, w_addr_inc;
    logic w_bit8, w_addr_match, w_mack_ok;
    logic [7:0] w_byte;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_scl       (i_scl_in),
        .i_sda       (i_sda_in),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start),
        .o_stop_det  (w_stop),
        .o_sda_s     (w_sda_s)
    );

    // Byte as it stands after shifting in the bit sampled at this SCL rise
    assign w_byte       = {r_shift[6:0], w_sda_s};
    assign w_bit8       = w_scl_rise && (r_bit_cnt == 4'd7);
    assign w_addr_match = (w_byte[7:1] == SLAVE_ADDR);
    assign w_mack_ok    = (r_state == MACK) && w_scl_rise && !w_sda_s;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state: START/STOP override every state
    always_comb begin
        w_state_nxt = r_state;
        if (w_start)     w_state_nxt = ADDR;
        else if (w_stop) w_state_nxt = IDLE;
        else begin
            unique case (r_state)
                IDLE:      w_state_nxt = IDLE;
                ADDR: begin
                    if (w_bit8 && !w_addr_match)                   w_state_nxt = IDLE;
                    else if (w_scl_fall && r_bit_cnt == 4'd8)      w_state_nxt = ADDR_ACK;
                end
                ADDR_ACK:  if (w_scl_fall) w_state_nxt = (r_rw == I2C_RW_READ) ? RDATA : REG;
                REG:       if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = REG_ACK;
                REG_ACK:   if (w_scl_fall) w_state_nxt = WDATA;
                WDATA:     if (w_scl_fall && r_bit_cnt == 4'd8) w_state_nxt = WDATA_ACK;
                WDATA_ACK: if (w_scl_fall) w_state_nxt = WDATA;
                RDATA:     if (w_scl_fall && !r_first && r_bit_cnt == 4'd7) w_state_nxt = MACK;
                MACK:      if (w_scl_rise) w_state_nxt = w_sda_s ? IDLE : RDATA;
                default:   w_state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: strobes and datapath enables for this clk
    always_comb begin
        w_rx_state  = (r_state == ADDR) || (r_state == REG) || (r_state == WDATA);
        w_shift_rx  = w_scl_rise && w_rx_state && (r_bit_cnt < 4'd8);
        w_ack_drive = w_scl_fall && w_rx_state && (r_bit_cnt == 4'd8);
        w_we        = w_bit8 && (r_state == WDATA);
        // Read fetch issued at the address ACK so data is ready for the ACK's falling edge
        w_re        = ((r_state == ADDR) && w_ack_drive && (r_rw == I2C_RW_READ)) || w_mack_ok;
        w_addr_inc  = ((r_state == WDATA_ACK) && w_scl_fall) || w_mack_ok;
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_reg_addr  <= '0;
            r_reg_wdata <= '0;
            r_sda_oe    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_reg_re    <= 1'b0;
            r_re_d      <= 1'b0;
            r_busy      <= 1'b0;
            r_rw        <= I2C_RW_WRITE;
            r_first     <= 1'b0;
        end else begin
            r_reg_we <= w_we;
            r_reg_re <= w_re;
            r_re_d   <= r_reg_re;
            if (r_re_d)     r_shift     <= i_reg_rdata;
            if (w_addr_inc) r_reg_addr  <= r_reg_addr + 8'd1;
            if (w_we)       r_reg_wdata <= w_byte;
            if (w_start) begin
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_first   <= 1'b0;
            end else if (w_stop) begin
                r_bit_cnt <= '0;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_first   <= 1'b0;
            end else begin
                if (w_shift_rx) begin
                    r_shift   <= w_byte;
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (w_ack_drive) begin
                    r_sda_oe <= 1'b1;
                    if (r_state == ADDR) r_busy <= 1'b1;
                end
                unique case (r_state)
                    ADDR:  if (w_bit8) r_rw <= w_byte[0];
                    REG:   if (w_bit8) r_reg_addr <= w_byte;
                    ADDR_ACK: if (w_scl_fall) begin
                        r_bit_cnt <= '0;
                        r_sda_oe  <= (r_rw == I2C_RW_READ) ? ~r_shift[7] : 1'b0;
                    end
                    REG_ACK, WDATA_ACK: if (w_scl_fall) begin
                        r_bit_cnt <= '0;
                        r_sda_oe  <= 1'b0;
                    end
                    RDATA: if (w_scl_fall) begin
                        if (r_first) begin
                            r_first   <= 1'b0;
                            r_bit_cnt <= '0;
                            r_sda_oe  <= ~r_shift[7];
                        end else if (r_bit_cnt == 4'd7) begin
                            r_sda_oe  <= 1'b0;
                        end else begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_sda_oe  <= ~r_shift[6];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    MACK:  if (w_mack_ok) r_first <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign o_sda_oe    = r_sda_oe;
    assign o_reg_addr  = r_reg_addr;
    assign o_reg_wdata = r_reg_wdata;
    assign o_reg_we    = r_reg_we;
    assign o_reg_re    = r_reg_re;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench: bit-banged I2C controller, wired-AND SDA, register port model.
module tb_i2c_slave_regif;
    import i2c_pkg::*;

    localparam int Q = 10;  // clks per quarter SCL period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tb_scl = 1'b1;
    logic       tb_sda = 1'b1;
    logic       sda_bus;
    logic       sda_oe, reg_we, reg_re, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic [7:0] reg_rdata = 8'h00;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] we_addr_q[$];
    logic [7:0] we_data_q[$];
    logic [7:0] re_addr_q[$];
    logic       both_seen = 1'b0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;
    logic       mon_clr = 1'b0;

    always #5 clk = ~clk;

    assign sda_bus = tb_sda & ~sda_oe;

    i2c_slave_regif dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_scl_in    (tb_scl),
        .i_sda_in    (sda_bus),
        .o_sda_oe    (sda_oe),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .o_reg_we    (reg_we),
        .o_reg_re    (reg_re),
        .i_reg_rdata (reg_rdata),
        .o_busy      (busy)
    );

    function automatic logic [7:0] model_rd(input logic [7:0] a);
        case (a)
            8'h3B:   return 8'hA5;
            8'h3C:   return 8'h5A;
            default: return a ^ 8'h3C;
        endcase
    endfunction

    // Register-port model and transaction monitor
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= model_rd(reg_addr);
        if (reg_we) begin
            we_addr_q.push_back(reg_addr);
            we_data_q.push_back(reg_wdata);
        end
        if (reg_re) re_addr_q.push_back(reg_addr);
        if (reg_we && reg_re) both_seen <= 1'b1;
        if (mon_clr) begin
            oe_seen   <= 1'b0;
            busy_seen <= 1'b0;
        end else begin
            if (sda_oe) oe_seen <= 1'b1;
            if (busy)   busy_seen <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        tb_sda = 1'b1; wclk(Q);
        tb_scl = 1'b1; wclk(Q);
        tb_sda = 1'b0; wclk(Q);
        tb_scl = 1'b0; wclk(Q);
    endtask

    task automatic bus_stop();
        tb_sda = 1'b0; wclk(Q);
        tb_scl = 1'b1; wclk(Q);
        tb_sda = 1'b1; wclk(Q);
    endtask

    task automatic write_bit(input logic b);
        tb_sda = b;    wclk(Q);
        tb_scl = 1'b1; wclk(2*Q);
        tb_scl = 1'b0; wclk(Q);
    endtask

    task automatic read_bit(output logic b);
        tb_sda = 1'b1; wclk(Q);
        tb_scl = 1'b1; wclk(Q);
        b = sda_bus;   wclk(Q);
        tb_scl = 1'b0; wclk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~mack);
    endtask

    initial begin
        logic       ack, b;
        logic [7:0] d;
        int         we0, re0;

        // Reset state
        wclk(5);
        check("rst_sda_oe", sda_oe, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_reg_wdata", reg_wdata, 0);
        check("rst_we_re", {reg_we, reg_re}, 0);
        check("rst_busy", busy, 0);
        check("rst_state", 32'(dut.r_state), 32'(IDLE));
        rst = 1'b0;
        wclk(5);

        // Single write
        bus_start();
        write_byte(8'hD0, ack); check("sw_ack_addr", ack, 1);
        write_byte(8'h6B, ack); check("sw_ack_reg", ack, 1);
        check("sw_busy_mid", busy, 1);
        write_byte(8'h00, ack); check("sw_ack_data", ack, 1);
        bus_stop(); wclk(5);
        check("sw_we_count", we_addr_q.size(), 1);
        check("sw_we_addr", we_addr_q[0], 8'h6B);
        check("sw_we_data", we_data_q[0], 8'h00);
        check("sw_busy_after", busy, 0);
        check("sw_ptr_inc", reg_addr, 8'h6C);

        // Burst write with pointer wrap
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'hFE, ack);
        write_byte(8'h11, ack); check("bw_ack1", ack, 1);
        write_byte(8'h22, ack); check("bw_ack2", ack, 1);
        write_byte(8'h33, ack); check("bw_ack3", ack, 1);
        bus_stop(); wclk(5);
        check("bw_we_count", we_addr_q.size(), 4);
        check("bw_addr0", we_addr_q[1], 8'hFE);
        check("bw_data0", we_data_q[1], 8'h11);
        check("bw_addr1", we_addr_q[2], 8'hFF);
        check("bw_data1", we_data_q[2], 8'h22);
        check("bw_addr2_wrap", we_addr_q[3], 8'h00);
        check("bw_data2", we_data_q[3], 8'h33);
        check("bw_ptr_final", reg_addr, 8'h01);

        // Combined read: pointer write, repeated START, two-byte read
        we0 = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'h3B, ack);
        bus_start();
        write_byte(8'hD1, ack); check("rd_ack_addr", ack, 1);
        read_byte(d, 1'b1);     check("rd_byte0", d, 8'hA5);
        read_byte(d, 1'b0);     check("rd_byte1", d, 8'h5A);
        wclk(5);
        check("rd_release_nack", sda_oe, 0);
        bus_stop(); wclk(5);
        check("rd_re_count", re_addr_q.size(), 2);
        check("rd_re_addr0", re_addr_q[0], 8'h3B);
        check("rd_re_addr1", re_addr_q[1], 8'h3C);
        check("rd_no_we", we_addr_q.size(), we0);
        check("rd_ptr", reg_addr, 8'h3C);

        // Wrong address
        we0 = we_addr_q.size(); re0 = re_addr_q.size();
        mon_clr = 1'b1; wclk(2); mon_clr = 1'b0;
        bus_start();
        write_byte(8'hA0, ack); check("wa_no_ack_addr", ack, 0);
        write_byte(8'h55, ack); check("wa_no_ack_data", ack, 0);
        bus_stop(); wclk(5);
        check("wa_oe_never", oe_seen, 0);
        check("wa_busy_never", busy_seen, 0);
        check("wa_no_we", we_addr_q.size(), we0);
        check("wa_no_re", re_addr_q.size(), re0);

        // Abort: STOP in the middle of a data byte, then a new START
        we0 = we_addr_q.size();
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'h10, ack);
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        bus_stop(); wclk(5);
        bus_start();
        check("ab_state_addr", 32'(dut.r_state), 32'(ADDR));
        check("ab_sda_oe", sda_oe, 0);
        check("ab_no_we", we_addr_q.size(), we0);
        check("ab_ptr", reg_addr, 8'h10);
        bus_stop(); wclk(5);

        // Reset while driving a 0 bit in RDATA (0xA5: bit7=1, bit6=0)
        bus_start();
        write_byte(8'hD0, ack);
        write_byte(8'h3B, ack);
        bus_start();
        write_byte(8'hD1, ack);
        read_bit(b); check("mr_bit7", b, 1);
        check("mr_driving", sda_oe, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mr_sda_oe", sda_oe, 0);
        check("mr_reg_addr", reg_addr, 0);
        check("mr_we_re_busy", {reg_we, reg_re, busy}, 0);
        check("mr_state", 32'(dut.r_state), 32'(IDLE));
        wclk(3);
        rst = 1'b0;
        tb_sda = 1'b1; tb_scl = 1'b1;
        wclk(10);
        check("mr_idle_after", sda_oe, 0);
        check("we_re_exclusive", both_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
